// File: rtl/dm_responder_if.sv
// Request/response bus between the core's data-memory port and its responder.
// Master drives the DM_CS/DM_R/DM_W request; slave returns a one-cycle ready/err pulse.
interface dm_responder_if;
   logic        DM_CS;
   logic        DM_R;
   logic        DM_W;
   logic [31:0] i_DM_addr;
   logic [31:0] i_DM_wdata;
   logic [31:0] o_DM_rdata;
   logic        o_DM_ready;
   logic        o_DM_err;

   modport master (
      output DM_CS, DM_R, DM_W, i_DM_addr, i_DM_wdata,
      input  o_DM_rdata, o_DM_ready, o_DM_err
   );

   modport slave (
      input  DM_CS, DM_R, DM_W, i_DM_addr, i_DM_wdata,
      output o_DM_rdata, o_DM_ready, o_DM_err
   );
endinterface

// File: rtl/dm_responder.sv
// Word-organised data-memory responder with configurable read latency and a
// one-cycle ready/err pulse; includes a combinational peek port for benches.
module dm_responder #(
   parameter logic [31:0] BASE     = 32'h1001_0000,
   parameter int unsigned DEPTH    = 1024,
   parameter int unsigned READ_LAT = 1
) (
   input  logic               inclk,
   input  logic               rst,
   dm_responder_if.slave      bus,
   input  logic [31:0]        test_dm_addr,
   output logic [31:0]        test_dm_data
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e        state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic          ok_q;
   logic [AW-1:0] idx_q;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [31:0]   mem [DEPTH];

   logic [31:0]   offset;
   logic [AW-1:0] idx_now;
   logic          addr_ok;
   logic          req_ok;
   logic          req_bad;
   logic          unused_peek;

   // Unsigned subtract: addresses below BASE wrap high and fail the >= test.
   assign offset  = bus.i_DM_addr - BASE;
   assign idx_now = offset[AW+1:2];
   assign addr_ok = (bus.i_DM_addr >= BASE) && (bus.i_DM_addr[1:0] == 2'b00) &&
                    ((offset >> 2) < 32'(DEPTH));
   assign req_ok  = bus.DM_CS && (bus.DM_R ^ bus.DM_W);
   assign req_bad = bus.DM_CS && bus.DM_R && bus.DM_W;

   assign test_dm_data = mem[test_dm_addr[AW-1:0]];
   assign unused_peek  = ^test_dm_addr[31:AW];

   always_ff @(posedge inclk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 2'd0;
         ok_q    <= 1'b0;
         idx_q   <= '0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (state_q == StIdle && req_ok) begin
            ok_q  <= addr_ok;
            idx_q <= idx_now;
         end
      end
   end

   // Writes commit on the acceptance edge; a later reset does not undo them.
   always_ff @(posedge inclk) begin
      if (!rst && state_q == StIdle && req_ok && bus.DM_W && addr_ok) begin
         mem[idx_now] <= bus.i_DM_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (req_bad) begin
               state_d = StResp;
               err_d   = 1'b1;
               rdata_d = 32'd0;
            end else if (req_ok && bus.DM_W) begin
               state_d = StResp;
               err_d   = !addr_ok;
            end else if (req_ok) begin
               if (READ_LAT == 1) begin
                  state_d = StResp;
                  err_d   = !addr_ok;
                  rdata_d = addr_ok ? mem[idx_now] : 32'd0;
               end else begin
                  state_d = StWait;
                  cnt_d   = 2'(READ_LAT - 2);
               end
            end
         end
         StWait: begin
            if (cnt_q == 2'd0) begin
               state_d = StResp;
               err_d   = !ok_q;
               rdata_d = ok_q ? mem[idx_q] : 32'd0;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.o_DM_ready = (state_q == StResp);
      bus.o_DM_err   = (state_q == StResp) && err_q;
      bus.o_DM_rdata = rdata_q;
   end

endmodule
